// File: rtl/ready_decoupler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ready_decoupler
// Purpose  : Backward-path register slice for a valid/ready stream. din_ready_o
//            comes straight from a flop, so there is no combinational path
//            from dout_ready_i to din_ready_o. A DEPTH-entry circular skid
//            FIFO holds beats accepted while the downstream is stalled.
// Ports    : clk          - clock, all flops on posedge
//            rst          - asynchronous, active-low reset
//            din_data_i   - upstream beat data      (DIN bits)
//            din_valid_i  - upstream beat valid
//            din_ready_o  - registered ready to upstream
//            dout_data_o  - downstream beat data    (DIN bits)
//            dout_valid_o - downstream beat valid
//            dout_ready_i - downstream ready
// Params   : DIN   - data width
//            DEPTH - skid FIFO entries (>= 1, any value)
// Config   : READY_DECOUPLER_FWD_REG_EN - when defined, an output register
//            drives dout_valid_o/dout_data_o (1-cycle first-beat latency,
//            total storage DEPTH+1). When undefined, an empty FIFO bypasses
//            din straight to dout with zero latency.
// Revision : 1.0 - initial release
// ============================================================================
module ready_decoupler #(
    parameter int DIN   = 16,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DIN-1:0] din_data_i,
    input  logic           din_valid_i,
    output logic           din_ready_o,
    output logic [DIN-1:0] dout_data_o,
    output logic           dout_valid_o,
    input  logic           dout_ready_i
);

    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            OW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DIN-1:0] mem_q [DEPTH];
    logic [PW-1:0]  w_ptr_q, w_ptr_d;
    logic [PW-1:0]  r_ptr_q, r_ptr_d;
    logic [OW-1:0]  occ_q, occ_d;
    logic           ready_q, ready_d;

    logic           up_xfer;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic [DIN-1:0] head;

    assign up_xfer     = din_valid_i & ready_q;
    assign fifo_empty  = (occ_q == '0);
    assign head        = mem_q[r_ptr_q];
    assign din_ready_o = ready_q;

`ifdef READY_DECOUPLER_FWD_REG_EN
    logic           oreg_valid_q, oreg_valid_d;
    logic [DIN-1:0] oreg_data_q, oreg_data_d;
    logic           oreg_load;

    // The output register refills whenever it is empty or being drained.
    // The FIFO head has priority so ordering is preserved; din only goes
    // directly into the output register when nothing is queued ahead of it.
    always_comb begin
        oreg_load    = ~oreg_valid_q | dout_ready_i;
        oreg_valid_d = oreg_valid_q;
        oreg_data_d  = oreg_data_q;
        push         = up_xfer;
        pop          = 1'b0;
        if (oreg_load) begin
            oreg_valid_d = ~fifo_empty | up_xfer;
            if (!fifo_empty) begin
                oreg_data_d = head;
                pop         = 1'b1;
            end else begin
                oreg_data_d = din_data_i;
                push        = 1'b0;
            end
        end
    end

    // Capacity counts the output register as one extra slot.
    always_comb begin
        ready_d = (int'(occ_d) + int'(oreg_valid_d)) < (DEPTH + 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oreg_valid_q <= 1'b0;
        end else begin
            oreg_valid_q <= oreg_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        oreg_data_q <= oreg_data_d;
    end

    assign dout_valid_o = oreg_valid_q;
    assign dout_data_o  = oreg_data_q;
`else
    // Empty FIFO: an accepted beat is presented downstream in the same cycle
    // and only stored if the downstream does not take it right away.
    always_comb begin
        dout_valid_o = fifo_empty ? up_xfer : 1'b1;
        dout_data_o  = fifo_empty ? din_data_i : head;
        push         = up_xfer & ~(fifo_empty & dout_ready_i);
        pop          = dout_valid_o & dout_ready_i & ~fifo_empty;
    end

    always_comb begin
        ready_d = int'(occ_d) < DEPTH;
    end
`endif

    always_comb begin
        occ_d   = occ_q + OW'(push) - OW'(pop);
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        if (push) begin
            w_ptr_d = (w_ptr_q == PTR_LAST) ? '0 : w_ptr_q + 1'b1;
        end
        if (pop) begin
            r_ptr_d = (r_ptr_q == PTR_LAST) ? '0 : r_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q   <= '0;
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            ready_q <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            ready_q <= ready_d;
        end
    end

    // Storage is deliberately not reset; contents are only visible while
    // occupancy says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[w_ptr_q] <= din_data_i;
        end
    end

endmodule
`default_nettype wire
